// File: rtl/axon_scheduler.sv
// Purpose : per-core axon scheduler; local router packets {dt, axon} set one bit in a
//           circular buffer of per-tick spike vectors, and each global tick emits and
//           clears the slot due for that tick.
// Latency : tick sampled in IDLE at cycle N -> spikes_valid pulse (with axon_spikes) at cycle N+2.
// Backpr. : none; din_wen is accepted every cycle in every state, and ticks that arrive
//           outside IDLE are dropped and flagged on tick_missed (sticky).
// Ports   : clk/reset_n (async active-low); din/din_wen from the router; tick from the
//           global timer; axon_spikes/spikes_valid to the token controller; ready (IDLE),
//           tick_missed (sticky overrun flag).
// Option  : define AXON_SCHEDULER_STATS_EN to add pkt_count[15:0], a saturating count of
//           din_wen cycles.
module axon_scheduler #(
  parameter int PACKET_WIDTH = 12,
  parameter int AXON_BITS    = 8,
  parameter int TICK_BITS    = 4,
  parameter int NUM_AXONS    = 256,
  parameter int NUM_TICKS    = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [PACKET_WIDTH-1:0] din,
  input  logic                    din_wen,
  input  logic                    tick,
  output logic [NUM_AXONS-1:0]    axon_spikes,
  output logic                    spikes_valid,
  output logic                    ready,
  output logic                    tick_missed
`ifdef AXON_SCHEDULER_STATS_EN
  ,
  output logic [15:0]             pkt_count
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    EMIT = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [TICK_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [NUM_AXONS-1:0]   slot_q [NUM_TICKS];
  logic [NUM_AXONS-1:0]   slot_d [NUM_TICKS];
  logic [NUM_AXONS-1:0]   axon_spikes_q, axon_spikes_d;
  logic                   tick_missed_q, tick_missed_d;

  // Packet decode
  logic [TICK_BITS-1:0]   wr_dt;
  logic [AXON_BITS-1:0]   wr_axon;
  logic [TICK_BITS-1:0]   wr_slot;
  logic [NUM_AXONS-1:0]   wr_onehot;
  logic                   load_hit;

  assign wr_dt   = din[PACKET_WIDTH-1:AXON_BITS];
  assign wr_axon = din[AXON_BITS-1:0];
  // Natural TICK_BITS-wide wrap gives the circular-buffer modulo for free.
  assign wr_slot = rd_ptr_q + wr_dt;

  always_comb begin
    wr_onehot          = '0;
    wr_onehot[wr_axon] = 1'b1;
  end

  // A write landing on the slot being drained this cycle must bypass storage,
  // otherwise the clear would wipe it or it would resurface NUM_TICKS ticks late.
  assign load_hit = (state_q == LOAD) && din_wen && (wr_slot == rd_ptr_q);

  // FSM next-state and datapath
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    axon_spikes_d = axon_spikes_q;
    tick_missed_d = tick_missed_q | (tick && (state_q != IDLE));

    case (state_q)
      IDLE: begin
        if (tick) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        axon_spikes_d = slot_q[rd_ptr_q] | (load_hit ? wr_onehot : '0);
        rd_ptr_d      = rd_ptr_q + TICK_BITS'(1);
        state_d       = EMIT;
      end
      EMIT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slot storage: clear the drained slot first, then merge the incoming write so
  // that a write to any other slot in the LOAD cycle still lands.
  always_comb begin
    slot_d = slot_q;
    if (state_q == LOAD) begin
      slot_d[rd_ptr_q] = '0;
    end
    if (din_wen && !load_hit) begin
      slot_d[wr_slot] = slot_d[wr_slot] | wr_onehot;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rd_ptr_q      <= '0;
      slot_q        <= '{default: '0};
      axon_spikes_q <= '0;
      tick_missed_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      rd_ptr_q      <= rd_ptr_d;
      slot_q        <= slot_d;
      axon_spikes_q <= axon_spikes_d;
      tick_missed_q <= tick_missed_d;
    end
  end

  assign axon_spikes  = axon_spikes_q;
  assign spikes_valid = (state_q == EMIT);
  assign ready        = (state_q == IDLE);
  assign tick_missed  = tick_missed_q;

`ifdef AXON_SCHEDULER_STATS_EN
  logic [15:0] pkt_count_q, pkt_count_d;

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (din_wen && (pkt_count_q != 16'hFFFF)) begin
      pkt_count_d = pkt_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count_q <= '0;
    end else begin
      pkt_count_q <= pkt_count_d;
    end
  end

  assign pkt_count = pkt_count_q;
`endif

endmodule

// File: tb/tb_axon_scheduler.sv
// Directed, table-driven bench for axon_scheduler: single-packet delivery delays from a
// vector table, then hand-written sequences for pointer wrap, LOAD-cycle bypass, missed
// ticks and mid-operation reset.
module tb_axon_scheduler;

  logic         clk;
  logic         reset_n;
  logic [11:0]  din;
  logic         din_wen;
  logic         tick;
  logic [255:0] axon_spikes;
  logic         spikes_valid;
  logic         ready;
  logic         tick_missed;

  int total = 0;
  int fails = 0;
  int pm    = 0;   // bench model of the read pointer

  typedef struct {
    logic [3:0] dt;
    logic [7:0] axon;
    int         deliver;  // accepted tick (1-based) that must carry the bit
  } vec_t;

  vec_t vecs [6];

  axon_scheduler dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .din          (din),
    .din_wen      (din_wen),
    .tick         (tick),
    .axon_spikes  (axon_spikes),
    .spikes_valid (spikes_valid),
    .ready        (ready),
    .tick_missed  (tick_missed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] bit_vec(input int a);
    logic [255:0] v;
    v    = '0;
    v[a] = 1'b1;
    return v;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_spikes"}, axon_spikes, '0);
    chk({tag, "_valid"}, {255'd0, spikes_valid}, 256'd0);
    chk({tag, "_ready"}, {255'd0, ready}, 256'd1);
    chk({tag, "_missed"}, {255'd0, tick_missed}, 256'd0);
  endtask

  // Writes one packet while the DUT is in IDLE; returns at the next falling edge.
  task automatic write_pkt(input logic [3:0] dt, input logic [7:0] ax);
    din     = {dt, ax};
    din_wen = 1'b1;
    @(negedge clk);
    din_wen = 1'b0;
  endtask

  // One accepted tick; optionally drives a packet during the LOAD cycle.
  task automatic do_tick(input bit wr_load, input logic [11:0] pkt, output logic [255:0] spk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("lat1_valid", {255'd0, spikes_valid}, 256'd0);
    chk("lat1_ready", {255'd0, ready}, 256'd0);
    if (wr_load) begin
      din     = pkt;
      din_wen = 1'b1;
    end
    @(negedge clk);
    din_wen = 1'b0;
    chk("lat2_valid", {255'd0, spikes_valid}, 256'd1);
    spk = axon_spikes;
    @(negedge clk);
    chk("lat3_valid", {255'd0, spikes_valid}, 256'd0);
    chk("lat3_ready", {255'd0, ready}, 256'd1);
    pm = (pm + 1) % 16;
  endtask

  task automatic apply_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    pm      = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] spk;
    logic [255:0] exp;

    vecs[0] = '{dt: 4'd0,  axon: 8'd5,   deliver: 1};
    vecs[1] = '{dt: 4'd3,  axon: 8'd255, deliver: 4};
    vecs[2] = '{dt: 4'd1,  axon: 8'd0,   deliver: 2};
    vecs[3] = '{dt: 4'd15, axon: 8'd128, deliver: 16};
    vecs[4] = '{dt: 4'd7,  axon: 8'd42,  deliver: 8};
    vecs[5] = '{dt: 4'd0,  axon: 8'd200, deliver: 1};

    reset_n = 1'b0;
    din     = '0;
    din_wen = 1'b0;
    tick    = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset("por");
    reset_n = 1'b1;
    @(negedge clk);

    // Single-packet delivery delays
    for (int i = 0; i < 6; i++) begin
      write_pkt(vecs[i].dt, vecs[i].axon);
      for (int t = 1; t <= vecs[i].deliver; t++) begin
        do_tick(1'b0, 12'd0, spk);
        exp = (t == vecs[i].deliver) ? bit_vec(int'(vecs[i].axon)) : '0;
        chk($sformatf("vec%0d_tick%0d", i, t), spk, exp);
      end
      if (i == 0) begin
        @(negedge clk);
        @(negedge clk);
        chk("hold_spikes", axon_spikes, bit_vec(5));
        do_tick(1'b0, 12'd0, spk);
        chk("second_tick_zero", spk, '0);
      end
    end

    // Several axons in one slot, with a duplicate write
    write_pkt(4'd2, 8'd10);
    write_pkt(4'd2, 8'd10);
    write_pkt(4'd2, 8'd20);
    write_pkt(4'd0, 8'd30);
    do_tick(1'b0, 12'd0, spk);
    chk("multi_t1", spk, bit_vec(30));
    do_tick(1'b0, 12'd0, spk);
    chk("multi_t2", spk, '0);
    do_tick(1'b0, 12'd0, spk);
    chk("multi_t3", spk, bit_vec(10) | bit_vec(20));

    // Pointer wrap: rd_ptr = 15, dt = 2 -> slot 1
    apply_reset();
    for (int t = 0; t < 15; t++) begin
      do_tick(1'b0, 12'd0, spk);
      chk($sformatf("adv_tick%0d", t), spk, '0);
    end
    write_pkt(4'd2, 8'd7);
    do_tick(1'b0, 12'd0, spk);
    chk("wrap_t1", spk, '0);
    do_tick(1'b0, 12'd0, spk);
    chk("wrap_t2", spk, '0);
    do_tick(1'b0, 12'd0, spk);
    chk("wrap_t3", spk, bit_vec(7));

    // LOAD-cycle write targeting rd_ptr = 4 goes straight to the output
    while (pm != 4) begin
      do_tick(1'b0, 12'd0, spk);
      chk("seek4", spk, '0);
    end
    do_tick(1'b1, {4'd0, 8'd9}, spk);
    chk("load_bypass", spk, bit_vec(9));
    for (int t = 1; t <= 16; t++) begin
      do_tick(1'b0, 12'd0, spk);
      chk($sformatf("slot4_clear_t%0d", t), spk, '0);
    end
    // LOAD-cycle write to a different slot lands normally
    do_tick(1'b1, {4'd1, 8'd3}, spk);
    chk("load_other_now", spk, '0);
    do_tick(1'b0, 12'd0, spk);
    chk("load_other_next", spk, bit_vec(3));

    // Ticks during LOAD and EMIT are dropped and flagged
    chk("missed_before", {255'd0, tick_missed}, 256'd0);
    write_pkt(4'd1, 8'd50);
    tick = 1'b1;
    @(negedge clk);
    chk("burst_load_ready", {255'd0, ready}, 256'd0);
    @(negedge clk);
    chk("burst_emit_valid", {255'd0, spikes_valid}, 256'd1);
    chk("burst_emit_spikes", axon_spikes, '0);
    @(negedge clk);
    tick = 1'b0;
    pm   = (pm + 1) % 16;
    chk("burst_idle_ready", {255'd0, ready}, 256'd1);
    chk("missed_set", {255'd0, tick_missed}, 256'd1);
    @(negedge clk);
    chk("missed_sticky", {255'd0, tick_missed}, 256'd1);
    do_tick(1'b0, 12'd0, spk);
    chk("single_advance", spk, bit_vec(50));
    apply_reset();

    // Reset in the middle of LOAD
    write_pkt(4'd0, 8'd77);
    do_tick(1'b0, 12'd0, spk);
    chk("pre_rst_spikes", spk, bit_vec(77));
    write_pkt(4'd2, 8'd1);
    write_pkt(4'd2, 8'd2);
    write_pkt(4'd2, 8'd3);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    chk("midload_ready", {255'd0, ready}, 256'd0);
    reset_n = 1'b0;
    #1;
    check_reset("midload_rst");
    @(negedge clk);
    reset_n = 1'b1;
    pm      = 0;
    @(negedge clk);
    for (int t = 1; t <= 16; t++) begin
      do_tick(1'b0, 12'd0, spk);
      chk($sformatf("post_rst_t%0d", t), spk, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", total, fails);
    $finish;
  end

endmodule

// File: doc/axon_scheduler.md
Name: axon_scheduler

Overview:
- Sits directly downstream of the core router's local output port and consumes its local packets and their write strobe.
- Each local packet carries a delivery delay (dt) and a destination axon index.
- The block stores each packet as one bit in a circular buffer of per-tick spike vectors.
- On every global tick it presents the spike vector due for that tick to the token controller, then clears that slot for reuse.

Parameters:
- PACKET_WIDTH, 12, width of the local packet from the router; must equal TICK_BITS+AXON_BITS.
- AXON_BITS, 8, width of the axon index field in din[AXON_BITS-1:0].
- TICK_BITS, 4, width of the dt field in din[PACKET_WIDTH-1:AXON_BITS].
- NUM_AXONS, 256, axons per core; equals 2**AXON_BITS.
- NUM_TICKS, 16, slots in the circular buffer; equals 2**TICK_BITS.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- din  input  PACKET_WIDTH  local packet from the router: {dt, axon}.
- din_wen  input  1  packet-valid strobe from the router; one packet per cycle.
- tick  input  1  global timestep pulse.
- axon_spikes  output  NUM_AXONS  spike vector for the current tick; bit i set means axon i fires.
- spikes_valid  output  1  one-cycle pulse qualifying axon_spikes.
- ready  output  1  high when in IDLE, meaning a tick will be accepted.
- tick_missed  output  1  sticky flag, set when a tick arrives while not IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All slot bits = 0; read pointer rd_ptr = 0; state = IDLE.
  - axon_spikes = 0, spikes_valid = 0, tick_missed = 0, ready = 1.
- Storage: NUM_TICKS x NUM_AXONS flop array; slot[s][a] is one bit.
- Write path: on a cycle with din_wen=1:
  - Target slot = (rd_ptr + dt) mod NUM_TICKS (TICK_BITS-wide add, natural wrap).
  - slot[target][axon] <= 1.
  - Writes are accepted in every state; there is no backpressure.
  - Duplicate writes are idempotent.
- Delivery rule: a packet written while rd_ptr=p with delay d is delivered by the (d+1)th accepted tick after the write.
- FSM states: IDLE, LOAD, EMIT.
  - IDLE: ready=1. tick=1 -> LOAD.
  - LOAD (one cycle):
    - axon_spikes <= slot[rd_ptr], ORed with the bit from any same-cycle write whose target == rd_ptr.
    - slot[rd_ptr] <= 0, with the same-cycle write to rd_ptr suppressed; that write goes to the output instead.
    - rd_ptr <= rd_ptr+1 mod NUM_TICKS.
    - -> EMIT.
  - EMIT (one cycle): spikes_valid=1 -> IDLE.
- Latency: tick sampled high in cycle N -> spikes_valid high in cycle N+2.
- axon_spikes holds its value until the next LOAD.
- A same-cycle write in LOAD targeting a slot other than rd_ptr proceeds normally.
- A tick sampled in LOAD or EMIT is ignored and sets tick_missed; only reset clears tick_missed.
- Reset asserted mid-operation aborts the FSM to IDLE, clears all storage, and drops any pending delivery.

Optional Feature:
- Macro: AXON_SCHEDULER_STATS_EN.
- When defined, adds output pkt_count [15:0]:
  - Counts din_wen cycles.
  - Saturates at 16'hFFFF.
  - Reset to 0.
- When not defined, the port and counter do not exist; all other behaviour is identical.

Test Plan:
1. After reset, din={4'd0,8'd5} with din_wen=1, then tick -> 2 cycles later spikes_valid=1 and axon_spikes has only bit 5 set; a second tick -> axon_spikes=0.
2. din={4'd3,8'd255} -> ticks 1-3 give all-zero vectors; tick 4 gives bit 255 only.
3. Advance rd_ptr to 15 with 15 ticks, then din={4'd2,8'd7} -> bit 7 appears on the 3rd subsequent tick (slot 1, wrap).
4. din={4'd0,8'd9} in the LOAD cycle with rd_ptr=4 -> bit 9 appears in this EMIT; slot 4 reads 0 after 16 more ticks.
5. Tick asserted during LOAD and during EMIT -> both ignored, tick_missed=1, rd_ptr advanced only once; reset clears tick_missed to 0.
6. Write 3 packets to slot 2, assert reset_n=0 for 1 cycle mid-LOAD -> all outputs return to reset values; subsequent 16 ticks deliver all-zero vectors.
